// File: rtl/axis_mem_streamer_pkg.sv
// Shared definitions for the memory-backed AXI-Stream source: FSM encoding
// and the all-ones byte-strobe derivation.
package axis_mem_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int MAX_STRB_W = 128;

  function automatic logic [MAX_STRB_W-1:0] strb_ones(input int nbytes);
    logic [MAX_STRB_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      if (i < nbytes) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_mem_streamer_ram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old word.
module axis_mem_streamer_ram #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_mem_streamer.sv
// Memory-backed AXI-Stream source with a 2-entry prefetch buffer.
// Optional packet counter output enabled by AXIS_MEM_STREAMER_PKT_CNT_EN.
module axis_mem_streamer
  import axis_mem_streamer_pkg::*;
#(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 16
) (
  input  logic                    m_axis_aclk,
  input  logic                    m_axis_aresetn,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     xfer_len,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done
`ifdef AXIS_MEM_STREAMER_PKT_CNT_EN
  ,
  output logic [15:0]             pkt_count
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [STRB_W-1:0] STRB_ONES = STRB_W'(strb_ones(STRB_W));
  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] PKT_LAST = PW'(PKT_LEN - 1);
  localparam logic [PW-1:0] PKT_ONE = PW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  state_t                r_state;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH:0]   r_rd_idx;
  logic [PW-1:0]         r_pkt_pos;
  logic                  r_infl;
  logic                  r_infl_last;
  logic                  r_infl_final;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic [1:0]            r_buf_final;
  logic [1:0]            r_occ;

  logic                  w_valid;
  logic                  w_pop;
  logic [2:0]            w_level;
  logic                  w_rd_state;
  logic                  w_issue;
  logic                  w_last_read;
  logic                  w_beat_last;
  logic                  w_final_hs;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_valid     = (r_occ != 2'd0);
  assign w_pop       = w_valid & m_axis_tready;
  // Level counts the slot being freed this cycle so a pop and an issue can overlap.
  assign w_level     = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
  // Continuous mode keeps prefetching the next pass while the current one drains.
  assign w_rd_state  = (r_state == ST_STREAM) || ((r_state == ST_DRAIN) && r_mode);
  assign w_issue     = w_rd_state & enable & (w_level < 3'd2);
  assign w_last_read = (r_rd_idx == r_len - LEN_ONE);
  assign w_beat_last = (r_pkt_pos == PKT_LAST) || w_last_read;
  assign w_final_hs  = w_pop & r_buf_final[0];

  axis_mem_streamer_ram #(
    .MEM_SIZE  (MEM_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .i_clk    (m_axis_aclk),
    .i_wr_en  (wr_en),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .i_rd_en  (w_issue),
    .i_rd_addr(r_rd_addr),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_state      <= ST_IDLE;
      r_mode       <= 1'b0;
      r_start      <= '0;
      r_len        <= '0;
      r_rd_addr    <= '0;
      r_rd_idx     <= '0;
      r_pkt_pos    <= '0;
      r_infl       <= 1'b0;
      r_infl_last  <= 1'b0;
      r_infl_final <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_infl       <= w_issue;
      r_infl_last  <= w_beat_last;
      r_infl_final <= w_last_read;
      if (w_issue) begin
        if (w_last_read) begin
          r_rd_addr <= r_start;
          r_rd_idx  <= '0;
          r_pkt_pos <= '0;
        end else begin
          r_rd_addr <= r_rd_addr + ADDR_ONE;
          r_rd_idx  <= r_rd_idx + LEN_ONE;
          r_pkt_pos <= (r_pkt_pos == PKT_LAST) ? '0 : r_pkt_pos + PKT_ONE;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            if (xfer_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_mode    <= mode;
              r_start   <= start_addr;
              r_len     <= xfer_len;
              r_rd_addr <= start_addr;
              r_rd_idx  <= '0;
              r_pkt_pos <= '0;
              r_state   <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (w_issue && w_last_read) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_final_hs) begin
            if (!r_mode) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else if (!(w_issue && w_last_read)) begin
              r_state <= ST_STREAM;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Entry 0 is always the head; entry 1 only fills while the head is stalled.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_occ       <= '0;
      r_buf_last  <= '0;
      r_buf_final <= '0;
      for (int i = 0; i < 2; i++) r_buf_data[i] <= '0;
    end else begin
      case ({r_infl, w_pop})
        2'b10: begin
          r_buf_data[r_occ[0]]  <= w_rd_data;
          r_buf_last[r_occ[0]]  <= r_infl_last;
          r_buf_final[r_occ[0]] <= r_infl_final;
          r_occ                 <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf_data[0]  <= r_buf_data[1];
          r_buf_last[0]  <= r_buf_last[1];
          r_buf_final[0] <= r_buf_final[1];
          r_occ          <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf_data[0]  <= w_rd_data;
            r_buf_last[0]  <= r_infl_last;
            r_buf_final[0] <= r_infl_final;
          end else begin
            r_buf_data[0]  <= r_buf_data[1];
            r_buf_last[0]  <= r_buf_last[1];
            r_buf_final[0] <= r_buf_final[1];
            r_buf_data[1]  <= w_rd_data;
            r_buf_last[1]  <= r_infl_last;
            r_buf_final[1] <= r_infl_final;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXIS_MEM_STREAMER_PKT_CNT_EN
  logic [15:0] r_pkt_count;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_pkt_count <= '0;
    end else if (w_pop && r_buf_last[0]) begin
      r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign pkt_count = r_pkt_count;
`endif

  assign m_axis_tdata  = r_buf_data[0];
  assign m_axis_tvalid = w_valid;
  assign m_axis_tlast  = w_valid & r_buf_last[0];
  assign m_axis_tstrb  = w_valid ? STRB_ONES : '0;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_axis_mem_streamer.sv
// Randomized bench for axis_mem_streamer against a queue-based stream model.
module tb_axis_mem_streamer;

  localparam int MEM_SIZE = 4096;
  localparam int AW       = 12;
  localparam int DW       = 32;
  localparam int PKT_LEN  = 16;
  localparam int SW       = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   xfer_len = '0;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic [SW-1:0] tstrb;
  logic          tvalid;
  logic          tlast;
  logic          busy;
  logic          done;
`ifdef AXIS_MEM_STREAMER_PKT_CNT_EN
  logic [15:0]   pkt_count;
`endif

  always #5 clk = ~clk;

  axis_mem_streamer #(
    .MEM_SIZE  (MEM_SIZE),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .enable        (enable),
    .mode          (mode),
    .start_addr    (start_addr),
    .xfer_len      (xfer_len),
    .m_axis_tdata  (tdata),
    .m_axis_tstrb  (tstrb),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .busy          (busy),
    .done          (done)
`ifdef AXIS_MEM_STREAMER_PKT_CNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          fin;
  } beat_t;

  logic [DW-1:0] mem_model [MEM_SIZE];
  beat_t         exp_q [$];
  beat_t         mon_beat;
  logic [SW-1:0] strb_all = '1;

  bit            mon_en = 1'b0;
  bit            chk_done = 1'b1;
  bit            cur_mode = 1'b0;
  bit            pend_done = 1'b0;
  bit            stalled_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int            cyc = 0;
  int            hs_run = 0;
  int            first_hs = 0;
  int            last_hs = 0;
  int            ready_mode = 0;
  int            phase = 0;

  // Expected beats of one pass, derived directly from window start/length.
  task automatic queue_pass(input int start, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = mem_model[(start + i) % MEM_SIZE];
      b.last = (((i + 1) % PKT_LEN) == 0) || (i + 1 == len);
      b.fin  = (i + 1 == len);
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      stalled_prev = 1'b0;
      pend_done    = 1'b0;
    end else if (mon_en) begin
      if (chk_done) check_eq("done", 64'(done), 64'(pend_done));
      check_eq("tstrb", 64'(tstrb), tvalid ? 64'(strb_all) : 64'd0);
      if (stalled_prev) begin
        check_eq("hold_valid", 64'(tvalid), 64'd1);
        check_eq("hold_data", 64'(tdata), 64'(prev_data));
        check_eq("hold_last", 64'(tlast), 64'(prev_last));
      end
      pend_done = 1'b0;
      if (tvalid && tready) begin
        check_eq("beat_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_beat = exp_q.pop_front();
          check_eq("tdata", 64'(tdata), 64'(mon_beat.data));
          check_eq("tlast", 64'(tlast), 64'(mon_beat.last));
          pend_done = mon_beat.fin && !cur_mode;
        end
        if (hs_run == 0) first_hs = cyc;
        last_hs = cyc;
        hs_run++;
      end
      stalled_prev = tvalid && !tready;
      prev_data    = tdata;
      prev_last    = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (done) enable = 1'b0;
    case (ready_mode)
      0:       tready = 1'b1;
      1:       tready = ((phase % 3) == 0);
      default: tready = ($urandom_range(0, 9) < 7);
    endcase
    phase++;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_tvalid"}, 64'(tvalid), 64'd0);
    check_eq({pfx, "_tlast"}, 64'(tlast), 64'd0);
    check_eq({pfx, "_tstrb"}, 64'(tstrb), 64'd0);
    check_eq({pfx, "_tdata"}, 64'(tdata), 64'd0);
    check_eq({pfx, "_busy"}, 64'(busy), 64'd0);
    check_eq({pfx, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic run_single(input int start, input int len, input int rmode, input int pause_at);
    int lat;
    int hs_drop;
    bit paused;
    int max_c;
    lat     = -1;
    hs_drop = 0;
    paused  = 1'b0;
    max_c   = 6 * len + 60;
    ready_mode = rmode;
    tick();
    queue_pass(start, len);
    cur_mode   = 1'b0;
    hs_run     = 0;
    mode       = 1'b0;
    start_addr = AW'(start);
    xfer_len   = (AW + 1)'(len);
    enable     = 1'b1;
    for (int c = 0; c < max_c; c++) begin
      tick();
      if (lat < 0 && tvalid) lat = c;
      if (pause_at > 0 && !paused && hs_run >= pause_at) begin
        paused  = 1'b1;
        enable  = 1'b0;
        hs_drop = hs_run;
        repeat (10) tick();
        check_eq("pause_valid_low", 64'(tvalid), 64'd0);
        check_eq("pause_extra_le2", 64'((hs_run - hs_drop) <= 2), 64'd1);
        enable = 1'b1;
      end
      if (exp_q.size() == 0 && !busy) break;
    end
    check_eq("beats_left", 64'(exp_q.size()), 64'd0);
    check_eq("busy_end", 64'(busy), 64'd0);
    if (pause_at == 0) check_eq("latency", 64'(lat), 64'd2);
    if (rmode == 0 && pause_at == 0) check_eq("throughput", 64'(last_hs - first_hs), 64'(len - 1));
    $display("pass start=%0d len=%0d ready_mode=%0d pause_at=%0d beats=%0d latency=%0d",
             start, len, rmode, pause_at, hs_run, lat);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
    check_outputs_zero("post_rst");

    for (int i = 0; i < MEM_SIZE; i++) begin
      wr_en        = 1'b1;
      wr_addr      = AW'(i);
      wr_data      = $urandom;
      mem_model[i] = wr_data;
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      wr_en        = 1'b1;
      wr_addr      = AW'(i);
      wr_data      = DW'(32'h100 + i);
      mem_model[i] = wr_data;
      tick();
    end
    wr_en = 1'b0;
    tick();
    $display("load words=%0d", MEM_SIZE + 32);

    run_single(0, 32, 0, 0);
    run_single(4094, 4, 0, 0);
    run_single(100, 20, 1, 0);
    run_single(200, 30, 0, 10);

    ready_mode = 0;
    tick();
    chk_done   = 1'b0;
    mode       = 1'b0;
    start_addr = AW'(5);
    xfer_len   = '0;
    enable     = 1'b1;
    tick();
    check_eq("zero_len_done", 64'(done), 64'd1);
    check_eq("zero_len_busy", 64'(busy), 64'd0);
    tick();
    check_eq("zero_len_done_clr", 64'(done), 64'd0);
    repeat (3) tick();
    check_eq("zero_len_no_beat", 64'(tvalid), 64'd0);
    chk_done = 1'b1;
    $display("pass start=5 len=0 done_pulse");

    ready_mode = 0;
    tick();
    cur_mode = 1'b1;
    hs_run   = 0;
    for (int p = 0; p < 6; p++) queue_pass(0, 3);
    mode       = 1'b1;
    start_addr = '0;
    xfer_len   = (AW + 1)'(3);
    enable     = 1'b1;
    for (int c = 0; c < 100 && hs_run < 12; c++) tick();
    check_eq("cont_beats", 64'(hs_run >= 12), 64'd1);
    check_eq("cont_no_bubble", 64'(last_hs - first_hs), 64'd11);
    check_eq("cont_busy", 64'(busy), 64'd1);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    exp_q.delete();
    cur_mode = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_outputs_zero("after_rst");
    $display("pass continuous start=0 len=3 beats=%0d then reset", hs_run);

    for (int r = 0; r < 4; r++) begin
      run_single(int'($urandom_range(0, MEM_SIZE - 1)), int'($urandom_range(1, 70)),
                 int'($urandom_range(0, 2)), 0);
    end

`ifdef AXIS_MEM_STREAMER_PKT_CNT_EN
    begin
      logic [15:0] before;
      before = pkt_count;
      run_single(0, 40, 0, 0);
      check_eq("pkt_count_delta", 64'(16'(pkt_count - before)), 64'd3);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_mem_streamer.md
# axis_mem_streamer

Parametrised memory-backed AXI-Stream source, the next generation of our memory-to-stream wrapper. Holds a local block RAM, loaded through a simple write port, and streams a programmable window of it out as AXI-Stream packets of configurable length. It supports full-throughput backpressure, address wrap-around, pause/resume and single-shot or continuous looping. It sits between the host/config logic that fills memory and any downstream AXIS consumer.

## Interface
- MEM_SIZE, 4096, memory depth in words (power of two)
- ADDR_WIDTH, 12, log2(MEM_SIZE)
- DATA_WIDTH, 32, word and tdata width (multiple of 8)
- PKT_LEN, 16, beats per packet; tlast period (>=1)

- m_axis_aclk  in  1  single clock for the whole block
- m_axis_aresetn  in  1  asynchronous, active-low reset
- wr_en  in  1  memory write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- enable  in  1  start (in IDLE) / continue (while streaming) request
- mode  in  1  0 = single pass, 1 = continuous loop; sampled at start
- start_addr  in  ADDR_WIDTH  first word of the window; sampled at start
- xfer_len  in  ADDR_WIDTH+1  beats per pass, 0..MEM_SIZE; sampled at start
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tstrb  out  DATA_WIDTH/8  byte strobes
- m_axis_tvalid  out  1  beat valid
- m_axis_tlast  out  1  packet end
- m_axis_tready  in  1  downstream ready
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at pass completion (single mode)

## Operation
- FSM: IDLE -> STREAM -> DRAIN -> IDLE.
- IDLE: enable=1 at an edge latches start_addr, xfer_len and mode, then moves to STREAM. If xfer_len=0, stays in IDLE and pulses done; no beats are produced.
- STREAM: issues synchronous reads (1-cycle RAM latency) into a 2-entry prefetch buffer. A read is issued only when buffer occupancy plus in-flight reads is <2 and enable=1.
- Read address increments modulo MEM_SIZE; start_addr+xfer_len past the top wraps to 0.
- Output is the buffer head. A handshake occurs when tvalid&tready. tstrb is all ones whenever tvalid=1, else 0.
- tlast=1 on every PKT_LEN-th beat of a pass, and on the final beat of a pass. The beat counter restarts at each pass.
- enable=0 while streaming pauses new reads only. Buffered beats are still presented. tvalid, once high, stays high with stable data until the handshake.
- All reads of a pass issued -> DRAIN. On the final handshake: single mode pulses done and returns to IDLE; continuous mode reloads start_addr and returns to STREAM.
- Write/read collision at the same address in the same cycle is read-first: the stream gets the old word. Writes are accepted in any state.
- enable and input changes during STREAM are ignored except as pause.

## Timing
- Reset (async assert, sync release): tvalid, tlast, tstrb, tdata, busy and done are 0, FSM is IDLE, buffer is empty, counters are 0. Reset mid-transfer discards in-flight beats.
- Start latency: enable sampled at edge k -> tvalid high after edge k+2.
- Throughput: 1 beat/cycle sustained with tready=1, including across packet boundaries and continuous-mode pass restarts (no bubble).
- Backpressure: tready low for N cycles -> no more than 2 beats buffered, no data loss or duplication.
- done: high for exactly the cycle after the final handshake edge.

## Configuration
- AXIS_MEM_STREAMER_PKT_CNT_EN defined: adds output pkt_count [15:0]. It increments on every tlast handshake, wraps at 65535, is cleared by reset only, and is not cleared by a new start.
- AXIS_MEM_STREAMER_PKT_CNT_EN undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package axis_mem_streamer_pkg holds the FSM state encoding (IDLE, STREAM, DRAIN) and the strobe-all-ones constant derivation.
- Sub-module axis_mem_streamer_ram: single-port-write, single-port-read synchronous RAM, read-first, MEM_SIZE x DATA_WIDTH.
- The FSM, prefetch buffer and counters are in the top module.

## Test plan
- Load words 0..31 with value addr+0x100, start_addr=0, xfer_len=32, PKT_LEN=16, mode=0, tready=1 -> 32 consecutive beats 0x100..0x11F, tlast on beats 16 and 32, done one cycle after beat 32, first tvalid 2 cycles after enable.
- start_addr=4094, xfer_len=4 -> data from addresses 4094, 4095, 0, 1; tlast on the 4th beat.
- Toggle tready with a 1-on/2-off pattern over 20 beats -> each beat delivered exactly once in order, tdata stable while tvalid && !tready.
- mode=1, xfer_len=3, PKT_LEN=16 -> repeating addr 0,1,2 with tlast every 3rd beat, no idle cycles between passes, done never pulses.
- Drop enable for 10 cycles mid-pass -> at most 2 more beats, then tvalid low; enable=1 resumes at the next address; assert reset mid-pass -> all outputs 0 immediately.
- Under AXIS_MEM_STREAMER_PKT_CNT_EN: xfer_len=40, PKT_LEN=16 -> pkt_count reaches 3 (lasts at beats 16, 32, 40).
